// File: rtl/hps_fpga_led_pio_pkg.sv
// +----------------------------------------------------------------------+
// | Module : hps_fpga_led_pio_pkg                                        |
// | Desc   : Register map, default widths and timer state encodings      |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package hps_fpga_led_pio_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
  localparam int unsigned DEFAULT_TIMER_WIDTH = 24;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RSVD1    = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_PERIOD   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_PHASE    = 3'd6;

  localparam logic [0:0] c_TMR_IDLE = 1'b0;
  localparam logic [0:0] c_TMR_RUN  = 1'b1;

endpackage : hps_fpga_led_pio_pkg

`default_nettype wire

// File: rtl/hps_fpga_led_pio_blink_timer.sv
// +----------------------------------------------------------------------+
// | Module : hps_fpga_led_pio_blink_timer                                |
// | Desc   : Reloading down-counter producing the LED blink phase        |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module hps_fpga_led_pio_blink_timer
  import hps_fpga_led_pio_pkg::*;
#(
  parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [TIMER_WIDTH-1:0] i_period,
  input  logic                   i_load,
  output logic                   o_phase
);

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [TIMER_WIDTH-1:0] r_cnt;
  logic                   r_phase;
  logic                   w_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_TMR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // i_period already carries the incoming value on a load cycle
  always_comb begin
    w_state_nxt = r_state;
    if (i_load) begin
      w_state_nxt = (i_period != '0) ? c_TMR_RUN : c_TMR_IDLE;
    end
  end

  always_comb begin
    w_run   = (r_state == c_TMR_RUN);
    o_phase = r_phase;
  end

  // A load always wins over a coincident terminal-count toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= i_period;
      r_phase <= 1'b0;
    end else if (w_run) begin
      if (r_cnt == '0) begin
        r_cnt   <= i_period;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end
  end

endmodule : hps_fpga_led_pio_blink_timer

`default_nettype wire

// File: rtl/hps_fpga_led_pio.sv
// +----------------------------------------------------------------------+
// | Module : hps_fpga_led_pio                                            |
// | Desc   : Avalon-MM LED PIO; optional blink via HPS_FPGA_LED_PIO_BLINK_EN|
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module hps_fpga_led_pio
  import hps_fpga_led_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [31:0]           r_readdata;
  logic [31:0]           w_rd_data;
  logic [31:0]           w_rd_mask;
  logic [31:0]           w_rd_period;
  logic [31:0]           w_rd_phase;
  logic [31:0]           w_rd_mux;
  logic                  w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data <= writedata[DATA_WIDTH-1:0];
        ADDR_OUTSET:   r_data <= r_data | writedata[DATA_WIDTH-1:0];
        ADDR_OUTCLEAR: r_data <= r_data & ~writedata[DATA_WIDTH-1:0];
        default:       r_data <= r_data;
      endcase
    end
  end

`ifdef HPS_FPGA_LED_PIO_BLINK_EN
  logic [DATA_WIDTH-1:0]  r_mask;
  logic [TIMER_WIDTH-1:0] r_period;
  logic [TIMER_WIDTH-1:0] w_period_nxt;
  logic                   w_period_load;
  logic                   w_phase;

  assign w_period_load = w_wr && (address == ADDR_PERIOD);
  assign w_period_nxt  = w_period_load ? writedata[TIMER_WIDTH-1:0] : r_period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '0;
      r_period <= '0;
    end else begin
      if (w_wr && (address == ADDR_MASK)) begin
        r_mask <= writedata[DATA_WIDTH-1:0];
      end
      r_period <= w_period_nxt;
    end
  end

  hps_fpga_led_pio_blink_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_blink_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_period (w_period_nxt),
    .i_load   (w_period_load),
    .o_phase  (w_phase)
  );

  always_comb begin
    w_rd_mask                     = '0;
    w_rd_mask[DATA_WIDTH-1:0]     = r_mask;
    w_rd_period                   = '0;
    w_rd_period[TIMER_WIDTH-1:0]  = r_period;
    w_rd_phase                    = {31'd0, w_phase};
  end

  assign out_port = r_data ^ (r_mask & {DATA_WIDTH{w_phase}});
`else
  assign w_rd_mask   = '0;
  assign w_rd_period = '0;
  assign w_rd_phase  = '0;
  assign out_port    = r_data;
`endif

  always_comb begin
    w_rd_data                 = '0;
    w_rd_data[DATA_WIDTH-1:0] = r_data;
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:   w_rd_mux = w_rd_data;
      ADDR_MASK:   w_rd_mux = w_rd_mask;
      ADDR_PERIOD: w_rd_mux = w_rd_period;
      ADDR_PHASE:  w_rd_mux = w_rd_phase;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;

endmodule : hps_fpga_led_pio

`default_nettype wire

// File: tb/tb_hps_fpga_led_pio.sv
// +----------------------------------------------------------------------+
// | Module : tb_hps_fpga_led_pio                                         |
// | Desc   : Directed + random bench with a cycle-count reference model  |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hps_fpga_led_pio;

`ifdef HPS_FPGA_LED_PIO_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  // Reference state: phase derived from edges elapsed since the last period load
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [23:0] m_per;
  int          m_cyc;
  int          m_load;

  hps_fpga_led_pio #(
    .DATA_WIDTH  (8),
    .TIMER_WIDTH (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic logic m_phase(input int c);
    if (m_per == 24'd0) return 1'b0;
    return 1'(((c - m_load) / (int'(m_per) + 1)) % 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input string tag, input logic cs, input logic wn,
                           input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        ph;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    ph = m_phase(m_cyc);
    case (a)
      3'd0:    exp_rd = {24'd0, m_data};
      3'd2:    exp_rd = BLINK_EN ? {24'd0, m_mask} : 32'd0;
      3'd3:    exp_rd = BLINK_EN ? {8'd0, m_per} : 32'd0;
      3'd6:    exp_rd = BLINK_EN ? {31'd0, ph} : 32'd0;
      default: exp_rd = 32'd0;
    endcase
    @(posedge clk);
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[7:0];
        3'd2: if (BLINK_EN) m_mask = wd[7:0];
        3'd3: if (BLINK_EN) begin m_per = wd[23:0]; m_load = m_cyc + 1; end
        3'd4: m_data = m_data | wd[7:0];
        3'd5: m_data = m_data & ~wd[7:0];
        default: ;
      endcase
    end
    m_cyc++;
    #1;
    ph = m_phase(m_cyc);
    check({tag, ".readdata"}, readdata, exp_rd);
    check({tag, ".out_port"}, {24'd0, out_port}, {24'd0, m_data ^ (m_mask & {8{ph}})});
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] wd);
    bus_cycle(tag, 1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input string tag, input logic [2:0] a);
    bus_cycle(tag, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    m_data = 8'd0;
    m_mask = 8'd0;
    m_per  = 24'd0;
    m_load = m_cyc;
    #1;
    check({tag, ".rst_out_port"}, {24'd0, out_port}, 32'd0);
    check({tag, ".rst_readdata"}, readdata, 32'd0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".rst_hold_out"}, {24'd0, out_port}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    m_cyc = 0;
    #2;
    do_reset("init");
    for (int a = 0; a < 8; a++) rd("init_rd", 3'(a));

    wr("a5_wr", 3'd0, 32'hFFFF_FFA5);
    rd("a5_rd", 3'd0);
    rd("a5_rd2", 3'd1);

    wr("set_data", 3'd0, 32'h0000_00F0);
    wr("outset", 3'd4, 32'h1234_560F);
    wr("outclr", 3'd5, 32'hABCD_EF30);
    rd("rd_outset", 3'd4);
    rd("rd_outclr", 3'd5);

    wr("blk_data", 3'd0, 32'h0);
    wr("blk_mask", 3'd2, 32'h0000_0081);
    wr("blk_per", 3'd3, 32'h0000_0003);
    for (int i = 0; i < 20; i++) rd("blk_phase", 3'd6);
    rd("blk_rd_per", 3'd3);

    wr("stop_per", 3'd3, 32'h0);
    for (int i = 0; i < 8; i++) rd("idle_static", 3'd6);

    wr("tc_per3", 3'd3, 32'h3);
    for (int i = 0; i < 3; i++) rd("tc_wait", 3'd6);
    wr("tc_per1", 3'd3, 32'h1);
    for (int i = 0; i < 8; i++) rd("tc_after", 3'd6);

    wr("mid_data", 3'd0, 32'h3C);
    wr("mid_mask", 3'd2, 32'hFF);
    wr("mid_per", 3'd3, 32'h2);
    for (int i = 0; i < 5; i++) rd("mid_run", 3'd6);
    do_reset("mid");
    for (int a = 0; a < 8; a++) rd("post_rst", 3'(a));

    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      logic        cs;
      logic        wn;
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 1) != 0);
      wd = $urandom;
      if (a == 3'd3) wd = (wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      if ($urandom_range(0, 399) == 0) do_reset("rnd");
      else bus_cycle("rnd", cs, wn, a, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hps_fpga_led_pio

`default_nettype wire
